// File: rtl/xor_sweep_ctrl.sv
// Exhaustive XOR cross-check sequencer: sweeps every (op_a, op_b) pair and counts result mismatches.
// Define XOR_SWEEP_FAILCAP_EN to latch the first failing operand pair on fail_valid/fail_a/fail_b.
module xor_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] res_ref,
  input  logic [WIDTH-1:0] res_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_e;

  localparam logic [WIDTH-1:0] ONES        = '1;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             pass_q, pass_d;
  logic [15:0]      err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic             mismatch;

  // Case inequality so an X or Z on either result also counts as a mismatch in simulation.
  assign mismatch = (res_ref !== res_dut);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          err_d        = '0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          op_a_d       = '0;
          op_b_d       = '0;
          cnt_d        = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`ifdef XOR_SWEEP_FAILCAP_EN
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_a_d     = op_a_q;
              fail_b_d     = op_b_q;
            end
`endif
          end
          // The last pair ends the sweep with both operands parked at all-ones.
          if (op_a_q == ONES && op_b_q == ONES) begin
            state_d = ST_DONE;
          end else begin
            op_b_d = op_b_q + WIDTH'(1);
            if (op_b_q == ONES) op_a_d = op_a_q + WIDTH'(1);
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        pass_d  = (err_q == 16'd0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef XOR_SWEEP_FAILCAP_EN
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
`else
  assign fail_valid = 1'b0;
  assign fail_a     = '0;
  assign fail_b     = '0;
`endif

endmodule
